// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, Q1.15 limits and the round/saturate helper for the DIF butterfly.
package fft_pkg;
   localparam int DW  = 16;
   localparam int LAT = 4;
   localparam int AW  = 2*DW+2;
   localparam logic signed [DW-1:0] Q15_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] Q15_MIN = {1'b1, {(DW-1){1'b0}}};
   typedef struct packed {
      logic          ovf;
      logic [DW-1:0] val;
   } rs_t;
   // Round half-up by 2^(s-1), arithmetic shift by s, then clamp to DW bits.
   function automatic rs_t round_sat(input logic signed [AW-1:0] v, input logic [5:0] s);
      logic signed [AW:0] r, t;
      logic [AW-DW+1:0] top;
      rs_t o;
      r = (s == 6'd0) ? '0 : (AW+1)'(1) << (s - 6'd1);
      t = ($signed({v[AW-1], v}) + r) >>> s;
      top = t[AW:DW-1];
      o.ovf = !((&top) || !(|top));
      o.val = o.ovf ? (t[AW] ? Q15_MIN : Q15_MAX) : t[DW-1:0];
      return o;
   endfunction
endpackage

// File: rtl/cplx_mult_q15.sv
// cplx_mult_q15: two-stage (X-Y)*W or (X-Y)*conj(W) multiply with full-width results.
module cplx_mult_q15 import fft_pkg::*; (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   input  logic                 inv_i,
   input  logic signed [DW:0]   dr_i,
   input  logic signed [DW:0]   di_i,
   input  logic signed [DW-1:0] wr_i,
   input  logic signed [DW-1:0] wi_i,
   output logic                 valid_o,
   output logic signed [AW-1:0] re_o,
   output logic signed [AW-1:0] im_o
);
   logic signed [2*DW:0] prr_d, pii_d, pir_d, pri_d, prr_q, pii_q, pir_q, pri_q;
   logic signed [AW-1:0] re_d, im_d, re_q, im_q;
   logic v2_q, inv2_q, v3_q;
   always_comb begin
      prr_d = (2*DW+1)'(dr_i) * (2*DW+1)'(wr_i);
      pii_d = (2*DW+1)'(di_i) * (2*DW+1)'(wi_i);
      pir_d = (2*DW+1)'(di_i) * (2*DW+1)'(wr_i);
      pri_d = (2*DW+1)'(dr_i) * (2*DW+1)'(wi_i);
      re_d  = inv2_q ? AW'(prr_q) + AW'(pii_q) : AW'(prr_q) - AW'(pii_q);
      im_d  = inv2_q ? AW'(pir_q) - AW'(pri_q) : AW'(pir_q) + AW'(pri_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {prr_q, pii_q, pir_q, pri_q} <= '0;
         {re_q, im_q} <= '0;
         {v2_q, inv2_q, v3_q} <= '0;
      end else begin
         {prr_q, pii_q, pir_q, pri_q} <= {prr_d, pii_d, pir_d, pri_d};
         {re_q, im_q} <= {re_d, im_d};
         {v2_q, inv2_q, v3_q} <= {valid_i, inv_i, v2_q};
      end
   end
   assign valid_o = v3_q;
   assign re_o    = re_q;
   assign im_o    = im_q;
endmodule

// File: rtl/ifft_butterfly_dif.sv
// ifft_butterfly_dif: pipelined radix-2 DIF butterfly, sum path out0 and twiddled difference out1.
module ifft_butterfly_dif import fft_pkg::*; #(
   parameter int DW  = fft_pkg::DW,
   parameter int LAT = fft_pkg::LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] x_real,
   input  logic signed [DW-1:0] x_imag,
   input  logic signed [DW-1:0] y_real,
   input  logic signed [DW-1:0] y_imag,
   input  logic signed [DW-1:0] w_real,
   input  logic signed [DW-1:0] w_imag,
   input  logic                 inv,
   input  logic                 scale,
   output logic signed [DW-1:0] out0_real,
   output logic signed [DW-1:0] out0_imag,
   output logic signed [DW-1:0] out1_real,
   output logic signed [DW-1:0] out1_imag,
   output logic                 out_valid,
   output logic                 ovf
);
   localparam int SD = LAT - 2;
   logic signed [DW:0] sr1_d, si1_d, dr1_d, di1_d, sr1_q, si1_q, dr1_q, di1_q;
   logic signed [DW-1:0] wr1_q, wi1_q;
   logic v1_q, inv1_q, sc1_q;
   logic signed [DW:0] srd_q [SD];
   logic signed [DW:0] sid_q [SD];
   logic scd_q [SD];
   logic mv;
   logic signed [AW-1:0] re, im;
   rs_t r0r, r0i, r1r, r1i;
   always_comb begin
      sr1_d = (DW+1)'(x_real) + (DW+1)'(y_real);
      si1_d = (DW+1)'(x_imag) + (DW+1)'(y_imag);
      dr1_d = (DW+1)'(x_real) - (DW+1)'(y_real);
      di1_d = (DW+1)'(x_imag) - (DW+1)'(y_imag);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {sr1_q, si1_q, dr1_q, di1_q, wr1_q, wi1_q} <= '0;
         {v1_q, inv1_q, sc1_q} <= '0;
      end else begin
         {sr1_q, si1_q, dr1_q, di1_q} <= {sr1_d, si1_d, dr1_d, di1_d};
         {wr1_q, wi1_q} <= {w_real, w_imag};
         {v1_q, inv1_q, sc1_q} <= {in_valid, inv, scale};
      end
   end
   cplx_mult_q15 u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (v1_q),
      .inv_i   (inv1_q),
      .dr_i    (dr1_q),
      .di_i    (di1_q),
      .wr_i    (wr1_q),
      .wi_i    (wi1_q),
      .valid_o (mv),
      .re_o    (re),
      .im_o    (im)
   );
   // Sum path and scale ride alongside the multiplier's two stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SD; i++) begin
            srd_q[i] <= '0;
            sid_q[i] <= '0;
            scd_q[i] <= 1'b0;
         end
      end else begin
         srd_q[0] <= sr1_q;
         sid_q[0] <= si1_q;
         scd_q[0] <= sc1_q;
         for (int i = 1; i < SD; i++) begin
            srd_q[i] <= srd_q[i-1];
            sid_q[i] <= sid_q[i-1];
            scd_q[i] <= scd_q[i-1];
         end
      end
   end
   always_comb begin
      r0r = round_sat(AW'(srd_q[SD-1]), {5'd0, scd_q[SD-1]});
      r0i = round_sat(AW'(sid_q[SD-1]), {5'd0, scd_q[SD-1]});
      r1r = round_sat(re, 6'(DW-1) + {5'd0, scd_q[SD-1]});
      r1i = round_sat(im, 6'(DW-1) + {5'd0, scd_q[SD-1]});
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {out0_real, out0_imag, out1_real, out1_imag} <= '0;
         {out_valid, ovf} <= '0;
      end else begin
         {out0_real, out0_imag} <= {r0r.val, r0i.val};
         {out1_real, out1_imag} <= {r1r.val, r1i.val};
         out_valid <= mv;
         ovf       <= mv & (r0r.ovf | r0i.ovf | r1r.ovf | r1i.ovf);
      end
   end
endmodule
